// File: rtl/irq_pending_encoder.sv
// irq_pending_encoder
//   Synchronises four asynchronous request lines and captures their rising
//   edges as sticky pending bits. Pending bits are gated by a writable enable
//   mask, and the highest enabled index (3 highest, 0 lowest) is granted to
//   the consumer through an irq/ack handshake.
//   SYNC_STAGES must be between 2 and 4.
module irq_pending_encoder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] MASK_RST    = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mask_we,
    input  logic [3:0] mask_din,
    input  logic       ack,
    output logic       irq,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic [3:0] mask
);

    typedef enum logic {
        ST_IDLE,
        ST_ASSERT
    } state_t;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] hist_q;
    logic [3:0] sync_s;
    logic [3:0] rise;
    logic [3:0] eligible;
    logic [1:0] enc_id;
    logic       enc_valid;

    state_t     state_q, state_d;
    logic       irq_d;
    logic [1:0] irq_id_d;
    logic [3:0] clear_vec;
    logic [3:0] pending_d;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    // History starts at 0, so a request already high at reset release is seen
    // as one rising edge.
    assign rise     = sync_s & ~hist_q;
    assign eligible = pending & mask;

    // Request synchroniser chains and edge-history register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_s;
        end
    end

    // Fixed-priority encode of the enabled pending bits, index 3 wins.
    always_comb begin
        // NOTE: defaults assigned first so no path through the block leaves a
        // variable unassigned, which would otherwise infer a latch.
        enc_valid = 1'b0;
        enc_id    = 2'b00;
        if (eligible[3]) begin
            enc_valid = 1'b1;
            enc_id    = 2'd3;
        end else if (eligible[2]) begin
            enc_valid = 1'b1;
            enc_id    = 2'd2;
        end else if (eligible[1]) begin
            enc_valid = 1'b1;
            enc_id    = 2'd1;
        end else if (eligible[0]) begin
            enc_valid = 1'b1;
            enc_id    = 2'd0;
        end
    end

    // Grant FSM next-state and handshake outputs; a grant is frozen until ack.
    always_comb begin
        state_d   = state_q;
        irq_d     = irq;
        irq_id_d  = irq_id;
        clear_vec = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    irq_id_d = enc_id;
                    irq_d    = 1'b1;
                    state_d  = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (ack) begin
                    clear_vec[irq_id] = 1'b1;
                    irq_d             = 1'b0;
                    state_d           = ST_IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // A new edge in the same cycle as its clear keeps the bit set.
        pending_d = (pending & ~clear_vec) | rise;
    end

    // FSM, handshake, pending and mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            irq     <= 1'b0;
            irq_id  <= 2'b00;
            pending <= 4'b0000;
            mask    <= MASK_RST;
        end else begin
            state_q <= state_d;
            irq     <= irq_d;
            irq_id  <= irq_id_d;
            pending <= pending_d;
            if (mask_we) begin
                mask <= mask_din;
            end
        end
    end

endmodule

// File: tb/tb_irq_pending_encoder.sv
// tb_irq_pending_encoder
//   Directed test of irq_pending_encoder with SYNC_STAGES=2, MASK_RST=4'hF.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_irq_pending_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       ack;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] mask;

    int total = 0;
    int bad   = 0;

    irq_pending_encoder #(
        .SYNC_STAGES(2),
        .MASK_RST   (4'b1111)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mask_we (mask_we),
        .mask_din(mask_din),
        .ack     (ack),
        .irq     (irq),
        .irq_id  (irq_id),
        .pending (pending),
        .mask    (mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Assert ack for exactly one edge.
    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we  = 1'b1;
        mask_din = m;
        tick();
        mask_we  = 1'b0;
    endtask

    task automatic check_grant(input string tag, input logic [1:0] id);
        check({tag, "_irq"}, {31'd0, irq}, 32'd1);
        check({tag, "_id"}, {30'd0, irq_id}, {30'd0, id});
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        mask_we  = 1'b0;
        mask_din = 4'b0000;
        ack      = 1'b0;
        #12;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_id", {30'd0, irq_id}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'h0);
        check("rst_mask", {28'd0, mask}, 32'hF);
        rst = 1'b0;
        tick(2);

        // 1. single request, exact latency, ack clears
        req = 4'b0100;
        tick(2);
        check("t1_pend_early", {28'd0, pending}, 32'h0);
        tick();
        check("t1_pend", {28'd0, pending}, 32'h4);
        check("t1_irq_early", {31'd0, irq}, 32'd0);
        req = 4'b0000;
        tick();
        check_grant("t1_grant", 2'd2);
        do_ack();
        check("t1_irq_off", {31'd0, irq}, 32'd0);
        check("t1_pend_clr", {28'd0, pending}, 32'h0);
        tick();
        check("t1_no_regrant", {31'd0, irq}, 32'd0);
        tick(2);

        // 2. simultaneous requests drain in priority order
        req = 4'b1011;
        tick(3);
        check("t2_pend0", {28'd0, pending}, 32'hB);
        tick();
        check_grant("t2_g3", 2'd3);
        do_ack();
        check("t2_gap1", {31'd0, irq}, 32'd0);
        check("t2_pend1", {28'd0, pending}, 32'h3);
        tick();
        check_grant("t2_g1", 2'd1);
        do_ack();
        check("t2_gap2", {31'd0, irq}, 32'd0);
        check("t2_pend2", {28'd0, pending}, 32'h1);
        tick();
        check_grant("t2_g0", 2'd0);
        do_ack();
        check("t2_pend3", {28'd0, pending}, 32'h0);
        req = 4'b0000;
        tick(3);

        // 3. mask suppresses index 3 until re-enabled
        write_mask(4'b0111);
        check("t3_mask", {28'd0, mask}, 32'h7);
        req = 4'b1001;
        tick(3);
        check("t3_pend", {28'd0, pending}, 32'h9);
        tick();
        check_grant("t3_g0", 2'd0);
        do_ack();
        check("t3_pend_after", {28'd0, pending}, 32'h8);
        tick();
        check("t3_masked", {31'd0, irq}, 32'd0);
        write_mask(4'hF);
        check("t3_mask_edge_irq", {31'd0, irq}, 32'd0);
        tick();
        check_grant("t3_g3", 2'd3);
        do_ack();
        check("t3_pend_done", {28'd0, pending}, 32'h0);
        req = 4'b0000;
        tick(3);

        // 4. no preemption; set wins over clear on the same bit
        req = 4'b0010;
        tick(4);
        check_grant("t4_g1", 2'd1);
        req = 4'b1000;
        tick(3);
        check_grant("t4_hold", 2'd1);
        check("t4_pend", {28'd0, pending}, 32'hA);
        req = 4'b1010;
        tick(2);
        check_grant("t4_hold2", 2'd1);
        do_ack();
        check("t4_irq_off", {31'd0, irq}, 32'd0);
        check("t4_set_wins", {28'd0, pending}, 32'hA);
        tick();
        check_grant("t4_g3", 2'd3);
        do_ack();
        check("t4_pend2", {28'd0, pending}, 32'h2);
        tick();
        check_grant("t4_regrant1", 2'd1);
        do_ack();
        check("t4_pend3", {28'd0, pending}, 32'h0);
        req = 4'b0000;
        tick(3);

        // 5. async reset mid-ASSERT, request held across release
        write_mask(4'b1110);
        req = 4'b1010;
        tick(3);
        check("t5_pend", {28'd0, pending}, 32'hA);
        tick();
        check_grant("t5_g3", 2'd3);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_irq", {31'd0, irq}, 32'd0);
        check("t5_rst_pend", {28'd0, pending}, 32'h0);
        check("t5_rst_mask", {28'd0, mask}, 32'hF);
        tick();
        rst = 1'b0;
        tick(3);
        check("t5_pend_rel", {28'd0, pending}, 32'hA);
        tick();
        check_grant("t5_rg3", 2'd3);
        do_ack();
        check("t5_pend_a", {28'd0, pending}, 32'h2);
        tick();
        check_grant("t5_rg1", 2'd1);
        do_ack();
        tick(3);
        check("t5_no_repeat_irq", {31'd0, irq}, 32'd0);
        check("t5_no_repeat_pend", {28'd0, pending}, 32'h0);
        req = 4'b0000;
        tick(3);

        // 6. ack held in IDLE is ignored; toggling request collapses to one bit
        ack = 1'b1;
        tick(3);
        check("t6_idle_ack_irq", {31'd0, irq}, 32'd0);
        write_mask(4'b1011);
        for (int i = 0; i < 4; i++) begin
            req = 4'b0100;
            tick(2);
            req = 4'b0000;
            tick(2);
        end
        tick(3);
        check("t6_pend_one", {28'd0, pending}, 32'h4);
        check("t6_ungranted", {31'd0, irq}, 32'd0);
        ack = 1'b0;
        write_mask(4'hF);
        tick();
        check_grant("t6_g2", 2'd2);
        do_ack();
        check("t6_pend_clr", {28'd0, pending}, 32'h0);
        tick(3);
        check("t6_single", {31'd0, irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog in case stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
